facto_ctrl: RTL and testbench

//  Memory-mapped control/sequencer for the FactoCore factorial engine. Holds the 8-bit-addressed, 64-bit

---
 rtl/facto_ctrl_if.sv | 12 +
 rtl/facto_ctrl.sv | 161 ++++++++++++++++
 tb/tb_facto_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/facto_ctrl_if.sv
// Slave-port bundle for the FactoCore control block: select, direction, address, write and read data.
// Latency: none, wires only. Backpressure: none; every selected access completes in one cycle.
interface facto_ctrl_if;
    logic        s_sel;
    logic        s_wr;
    logic [7:0]  s_addr;
    logic [63:0] s_din;
    logic [63:0] s_dout;

    modport master (output s_sel, s_wr, s_addr, s_din, input s_dout);
    modport slave  (input s_sel, s_wr, s_addr, s_din, output s_dout);
endinterface

// File: rtl/facto_ctrl.sv
// Factorial sequencer: register map plus a bit-serial 128-bit shift-add multiplier; optional intrEn under FACTO_INTR_EN.
// Latency: opdone 2 cycles after start for N<=1, else 2+MUL_BITS*(N-1); reads are combinational.
// Backpressure: none; writes that cannot be honoured (start/operand while busy, start in DONE) are dropped.
module facto_ctrl #(
    parameter int MUL_BITS = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    facto_ctrl_if.slave   bus,
    output logic          busy,
    output logic          interrupt
);
    localparam int CW = (MUL_BITS > 1) ? $clog2(MUL_BITS) : 1;

    typedef enum logic [1:0] {IDLE, INIT, MUL, DONE} state_t;

    state_t         r_state;
    logic           r_op_start;
    logic           r_done;
    logic [63:0]    r_operand;
    logic [63:0]    r_n;
    logic [63:0]    r_res_h;
    logic [63:0]    r_res_l;
    logic [127:0]   r_acc;
    logic [127:0]   r_mcand;
    logic [127:0]   r_mplr;
    logic [127:0]   r_prod;
    logic [CW-1:0]  r_bitcnt;

    logic           w_wr;
    logic           w_clear;
    logic           w_busy;
    logic           w_last;
    logic [127:0]   w_sum;
    logic [63:0]    w_n_dec;
    logic [63:0]    w_rdata;
    logic           w_intr_en;

    assign w_wr    = bus.s_sel & bus.s_wr;
    assign w_clear = w_wr && (bus.s_addr == 8'h08) && bus.s_din[0];
    assign w_busy  = (r_state == INIT) || (r_state == MUL);
    assign w_sum   = r_prod + (r_mplr[0] ? r_mcand : 128'd0);
    assign w_last  = (r_bitcnt == CW'(MUL_BITS - 1));
    assign w_n_dec = r_n - 64'd1;
    assign busy    = w_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_op_start <= 1'b0;
            r_done     <= 1'b0;
            r_operand  <= '0;
            r_n        <= '0;
            r_res_h    <= '0;
            r_res_l    <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplr     <= '0;
            r_prod     <= '0;
            r_bitcnt   <= '0;
        end else begin
            if (w_wr && (bus.s_addr == 8'h20) && !w_busy)
                r_operand <= bus.s_din;

            // Abort wins over whatever the sequencer was doing this cycle.
            if (w_clear) begin
                r_state    <= IDLE;
                r_op_start <= 1'b0;
                r_done     <= 1'b0;
                r_res_h    <= '0;
                r_res_l    <= '0;
                r_acc      <= '0;
                r_n        <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_wr && (bus.s_addr == 8'h00)) begin
                            r_op_start <= bus.s_din[0];
                            if (bus.s_din[0])
                                r_state <= INIT;
                        end
                    end
                    INIT: begin
                        r_acc <= 128'd1;
                        r_n   <= r_operand;
                        if (r_operand <= 64'd1) begin
                            r_state <= DONE;
                        end else begin
                            r_mcand  <= 128'd1;
                            r_mplr   <= {64'd0, r_operand};
                            r_prod   <= '0;
                            r_bitcnt <= '0;
                            r_state  <= MUL;
                        end
                    end
                    MUL: begin
                        r_mcand  <= r_mcand << 1;
                        r_mplr   <= r_mplr >> 1;
                        r_prod   <= w_sum;
                        r_bitcnt <= r_bitcnt + CW'(1);
                        // Full pass done: fold product into acc and either finish or start the next factor.
                        if (w_last) begin
                            r_acc <= w_sum;
                            r_n   <= w_n_dec;
                            if (w_n_dec <= 64'd1) begin
                                r_state <= DONE;
                            end else begin
                                r_mcand  <= w_sum;
                                r_mplr   <= {64'd0, w_n_dec};
                                r_prod   <= '0;
                                r_bitcnt <= '0;
                            end
                        end
                    end
                    DONE: begin
                        if (!r_done) begin
                            r_res_h <= r_acc[127:64];
                            r_res_l <= r_acc[63:0];
                            r_done  <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

`ifdef FACTO_INTR_EN
    logic r_intr_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_intr_en <= 1'b0;
        else if (w_wr && (bus.s_addr == 8'h18))
            r_intr_en <= bus.s_din[0];
    end

    assign w_intr_en = r_intr_en;
    assign interrupt = r_done & r_intr_en;
`else
    assign w_intr_en = 1'b0;
    assign interrupt = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        if (bus.s_sel && !bus.s_wr) begin
            case (bus.s_addr)
                8'h00:   w_rdata = {63'd0, r_op_start};
                8'h10:   w_rdata = {62'd0, w_busy, r_done};
                8'h18:   w_rdata = {63'd0, w_intr_en};
                8'h20:   w_rdata = r_operand;
                8'h28:   w_rdata = r_res_h;
                8'h30:   w_rdata = r_res_l;
                default: w_rdata = '0;
            endcase
        end
    end

    assign bus.s_dout = w_rdata;
endmodule

// File: tb/tb_facto_ctrl.sv
// Directed bench for facto_ctrl: stimulus pushes expected values, a negedge monitor pops and compares.
module tb_facto_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic busy;
    logic interrupt;

    facto_ctrl_if bus ();

    facto_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .busy      (busy),
        .interrupt (interrupt)
    );

    always #5 clk = ~clk;

`ifdef FACTO_INTR_EN
    localparam logic [63:0] EXP_INTR = 64'd1;
`else
    localparam logic [63:0] EXP_INTR = 64'd0;
`endif

    logic [63:0] exp_q[$];
    int          kind_q[$];
    string       name_q[$];
    logic        chk_vld = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always @(negedge clk) begin
        if (chk_vld) begin
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL scoreboard_underflow: got empty queue, required an entry");
            end else begin
                logic [63:0] e;
                logic [63:0] a;
                int          k;
                string       n;
                e = exp_q.pop_front();
                k = kind_q.pop_front();
                n = name_q.pop_front();
                a = (k == 0) ? bus.s_dout : (k == 1) ? {63'd0, busy} : {63'd0, interrupt};
                checks = checks + 1;
                if (a !== e) begin
                    errors = errors + 1;
                    $display("FAIL %s: got %h required %h", n, a, e);
                end
            end
        end
    end

    task automatic wr(input logic [7:0] a, input logic [63:0] d);
        bus.s_sel = 1'b1; bus.s_wr = 1'b1; bus.s_addr = a; bus.s_din = d;
        @(posedge clk); #1;
        bus.s_sel = 1'b0; bus.s_wr = 1'b0; bus.s_din = '0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [63:0] e, input string n);
        exp_q.push_back(e); kind_q.push_back(0); name_q.push_back(n);
        bus.s_sel = 1'b1; bus.s_wr = 1'b0; bus.s_addr = a; chk_vld = 1'b1;
        @(posedge clk); #1;
        bus.s_sel = 1'b0; chk_vld = 1'b0;
    endtask

    // kind 1 = busy pin, kind 2 = interrupt pin
    task automatic probe(input int k, input logic [63:0] e, input string n);
        exp_q.push_back(e); kind_q.push_back(k); name_q.push_back(n);
        chk_vld = 1'b1;
        @(posedge clk); #1;
        chk_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // After the start write returns, opdone must still read 0 at lat-1 and read 1 at lat.
    task automatic run(input logic [63:0] op, input int lat, input string n);
        wr(8'h20, op);
        wr(8'h00, 64'd1);
        idle(lat - 1);
        rd(8'h10, 64'd0, {n, "_opdone_early"});
        rd(8'h10, 64'd1, {n, "_opdone_on_time"});
    endtask

    initial begin
        bus.s_sel = 1'b0; bus.s_wr = 1'b0; bus.s_addr = '0; bus.s_din = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        rd(8'h00, 64'd0, "rst_op_start");
        rd(8'h08, 64'd0, "rst_opclear");
        rd(8'h10, 64'd0, "rst_opdone");
        rd(8'h18, 64'd0, "rst_intren");
        rd(8'h20, 64'd0, "rst_operand");
        rd(8'h28, 64'd0, "rst_result_h");
        rd(8'h30, 64'd0, "rst_result_l");
        probe(1, 64'd0, "rst_busy");
        probe(2, 64'd0, "rst_interrupt");

        wr(8'h18, 64'd1);
        run(64'd5, 258, "fact5");
        rd(8'h30, 64'h78, "fact5_result_l");
        rd(8'h28, 64'd0, "fact5_result_h");
        probe(2, EXP_INTR, "fact5_interrupt");
        rd(8'h18, EXP_INTR, "fact5_intren");
        rd(8'h00, 64'd1, "fact5_op_start");
        wr(8'h08, 64'd1);
        rd(8'h10, 64'd0, "clr_opdone");
        probe(2, 64'd0, "clr_interrupt");
        rd(8'h30, 64'd0, "clr_result_l");
        rd(8'h00, 64'd0, "clr_op_start");

        run(64'd0, 2, "fact0");
        rd(8'h30, 64'd1, "fact0_result_l");
        rd(8'h28, 64'd0, "fact0_result_h");
        wr(8'h08, 64'd1);
        run(64'd1, 2, "fact1");
        rd(8'h30, 64'd1, "fact1_result_l");
        wr(8'h08, 64'd1);

        run(64'd21, 2 + 64 * 20, "fact21");
        rd(8'h28, 64'h2, "fact21_result_h");
        rd(8'h30, 64'hC5077D36B8C40000, "fact21_result_l");
        wr(8'h08, 64'd1);
        run(64'd20, 2 + 64 * 19, "fact20");
        rd(8'h30, 64'h21C3677C82B40000, "fact20_result_l");
        rd(8'h28, 64'd0, "fact20_result_h");
        wr(8'h08, 64'd1);

        wr(8'h20, 64'd20);
        wr(8'h00, 64'd1);
        idle(97);
        probe(1, 64'd1, "abort_busy_before");
        rd(8'h10, 64'd2, "abort_opdone_busy");
        rd(8'h30, 64'd0, "abort_no_partial");
        wr(8'h08, 64'd1);
        probe(1, 64'd0, "abort_busy_after");
        rd(8'h10, 64'd0, "abort_opdone");
        rd(8'h28, 64'd0, "abort_result_h");
        rd(8'h30, 64'd0, "abort_result_l");
        rd(8'h00, 64'd0, "abort_op_start");
        rd(8'h20, 64'd20, "abort_operand_kept");
        rd(8'h18, EXP_INTR, "abort_intren_kept");
        run(64'd3, 130, "fact3");
        rd(8'h30, 64'd6, "fact3_result_l");
        wr(8'h08, 64'd1);

        wr(8'h20, 64'd7);
        wr(8'h00, 64'd1);
        idle(10);
        wr(8'h20, 64'd9);
        wr(8'h00, 64'd1);
        wr(8'h18, 64'd0);
        rd(8'h20, 64'd7, "busy_operand_ignored");
        rd(8'h00, 64'd1, "busy_op_start");
        idle(370);
        rd(8'h10, 64'd0, "fact7_opdone_early");
        rd(8'h10, 64'd1, "fact7_opdone_on_time");
        rd(8'h30, 64'h13B0, "fact7_result_l");
        wr(8'h30, 64'hFFFF);
        rd(8'h30, 64'h13B0, "ro_write_ignored");
        probe(2, 64'd0, "intren_cleared_irq");
        rd(8'h18, 64'd0, "intren_busy_write");
        rd(8'h38, 64'd0, "unmapped_read");
        rd(8'h08, 64'd0, "opclear_reads_zero");
        wr(8'h00, 64'd1);
        idle(3);
        rd(8'h10, 64'd1, "start_in_done_ignored");
        wr(8'h08, 64'd1);
        rd(8'h10, 64'd0, "final_clear");

        @(posedge clk); #1;
        if (exp_q.size() != 0) begin
            errors = errors + exp_q.size();
            $display("FAIL scoreboard_leftover: got %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
